// File: rtl/icap_pkg.sv
// Shared definitions for the ICAP readback engine: FSM state encoding and
// the default FIFO/ICAP word geometry.
package icap_pkg;

  localparam int DATA_SIZE      = 256;
  localparam int ICAP_DATA_SIZE = 32;
  localparam int WORDS_PER_LINE = DATA_SIZE / ICAP_DATA_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/icap_pack_buffer.sv
// Packs ICAP words into FIFO-wide lines and holds the finished line in an
// output register until the downstream FIFO accepts it.
module icap_pack_buffer #(
  parameter int DATA_SIZE      = icap_pkg::DATA_SIZE,
  parameter int ICAP_DATA_SIZE = icap_pkg::ICAP_DATA_SIZE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      capture,
  input  logic [ICAP_DATA_SIZE-1:0] capture_data,
  input  logic                      flush,
  input  logic                      fifo_full,
  output logic                      partial,
  output logic                      out_valid,
  output logic [DATA_SIZE-1:0]      out_data
);
  import icap_pkg::*;

  localparam int WORDS = DATA_SIZE / ICAP_DATA_SIZE;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [DATA_SIZE-1:0] pack_q, pack_d, pack_fill_s;
  logic [DATA_SIZE-1:0] out_q, out_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 out_valid_q, out_valid_d;

  // Next-state for packing slots and the output line; a new line wins over clearing out_valid.
  always_comb begin
    pack_d      = pack_q;
    idx_d       = idx_q;
    out_d       = out_q;
    out_valid_d = out_valid_q & fifo_full;
    pack_fill_s = pack_q;
    pack_fill_s[idx_q*ICAP_DATA_SIZE +: ICAP_DATA_SIZE] = capture_data;
    if (flush) begin
      out_d       = pack_q;
      out_valid_d = 1'b1;
      pack_d      = '0;
      idx_d       = '0;
    end else if (capture) begin
      if (idx_q == LAST_IDX) begin
        out_d       = pack_fill_s;
        out_valid_d = 1'b1;
        pack_d      = '0;
        idx_d       = '0;
      end else begin
        pack_d = pack_fill_s;
        idx_d  = idx_q + IDX_W'(1);
      end
    end else begin
      pack_d = pack_q;
    end
  end

  // Packing and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pack_q      <= '0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pack_q      <= pack_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign partial   = (idx_q != '0);
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

endmodule

// File: rtl/icap_readback.sv
// ICAP readback controller: issues word_count ICAP reads, packs the returned
// words into FIFO lines (zero-padding the tail) and pulses done at the end.
module icap_readback #(
  parameter int DATA_SIZE      = icap_pkg::DATA_SIZE,
  parameter int ICAP_DATA_SIZE = icap_pkg::ICAP_DATA_SIZE,
  parameter int FLAG_SIZE      = 1,
  parameter int COUNT_SIZE     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [FLAG_SIZE-1:0]      start,
  input  logic [COUNT_SIZE-1:0]     word_count,
  output logic [FLAG_SIZE-1:0]      icap_en,
  output logic [FLAG_SIZE-1:0]      icap_rdwr,
  input  logic [FLAG_SIZE-1:0]      icap_busy,
  input  logic [ICAP_DATA_SIZE-1:0] icap_data,
  input  logic [FLAG_SIZE-1:0]      fifo_full,
  output logic [FLAG_SIZE-1:0]      fifo_write_en,
  output logic [DATA_SIZE-1:0]      fifo_data,
  output logic [FLAG_SIZE-1:0]      busy,
  output logic [FLAG_SIZE-1:0]      done
);
  import icap_pkg::*;

  state_e                state_q, state_d;
  logic [COUNT_SIZE-1:0] issue_cnt_q, issue_cnt_d;
  logic [COUNT_SIZE-1:0] capture_cnt_q, capture_cnt_d;
  logic                  rd_pending_q, rd_pending_d;
  logic                  done_q, done_d;
  logic                  icap_en_s, accept_s, flush_s;
  logic                  out_valid_s, partial_s;

  // Reads stall while a finished line waits, so at most one extra word can land in the pack register.
  assign icap_en_s = (state_q == READ) && (issue_cnt_q != '0) && !out_valid_s;
  assign accept_s  = icap_en_s && !icap_busy[0];

  // Next-state, counters and completion pulse.
  always_comb begin
    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    capture_cnt_d = capture_cnt_q;
    rd_pending_d  = accept_s;
    done_d        = 1'b0;
    flush_s       = 1'b0;
    if (accept_s) begin
      issue_cnt_d = issue_cnt_q - COUNT_SIZE'(1);
    end else begin
      issue_cnt_d = issue_cnt_q;
    end
    if (rd_pending_q && (capture_cnt_q != '0)) begin
      capture_cnt_d = capture_cnt_q - COUNT_SIZE'(1);
    end else begin
      capture_cnt_d = capture_cnt_q;
    end
    case (state_q)
      IDLE: begin
        if (start[0]) begin
          issue_cnt_d   = word_count;
          capture_cnt_d = word_count;
          state_d       = (word_count == '0) ? DRAIN : READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (capture_cnt_q == '0) begin
          state_d = FLUSH;
        end else begin
          state_d = READ;
        end
      end
      FLUSH: begin
        if (!partial_s) begin
          state_d = DRAIN;
        end else if (!out_valid_s) begin
          flush_s = 1'b1;
          state_d = DRAIN;
        end else begin
          state_d = FLUSH;
        end
      end
      DRAIN: begin
        if (!out_valid_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; a read in flight at reset is dropped with rd_pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      issue_cnt_q   <= '0;
      capture_cnt_q <= '0;
      rd_pending_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      capture_cnt_q <= capture_cnt_d;
      rd_pending_q  <= rd_pending_d;
      done_q        <= done_d;
    end
  end

  icap_pack_buffer #(
    .DATA_SIZE      (DATA_SIZE),
    .ICAP_DATA_SIZE (ICAP_DATA_SIZE)
  ) u_pack (
    .clk          (clk),
    .reset        (reset),
    .capture      (rd_pending_q),
    .capture_data (icap_data),
    .flush        (flush_s),
    .fifo_full    (fifo_full[0]),
    .partial      (partial_s),
    .out_valid    (out_valid_s),
    .out_data     (fifo_data)
  );

  assign icap_en       = FLAG_SIZE'(icap_en_s);
  assign icap_rdwr     = FLAG_SIZE'(state_q == READ);
  assign fifo_write_en = FLAG_SIZE'(out_valid_s && !fifo_full[0]);
  assign busy          = FLAG_SIZE'(state_q != IDLE);
  assign done          = FLAG_SIZE'(done_q);

endmodule
